// File: rtl/sd_reg_pkg.sv
// Shared definitions for the SD host controller register bank: register map
// indices, default access masks for the SD host map, and the bus FSM state type.
package sd_reg_pkg;

  localparam int unsigned SD_NUM_REGS = 29;

  localparam int unsigned SDMA_ADDR     = 0;
  localparam int unsigned BLOCK         = 1;
  localparam int unsigned ARGUMENT      = 2;
  localparam int unsigned XFER_CMD      = 3;
  localparam int unsigned RESP0         = 4;
  localparam int unsigned RESP1         = 5;
  localparam int unsigned RESP2         = 6;
  localparam int unsigned RESP3         = 7;
  localparam int unsigned BUF_DATA      = 8;
  localparam int unsigned PRESENT_STATE = 9;
  localparam int unsigned INT_STAT      = 12;
  localparam int unsigned INT_STAT_EN   = 13;
  localparam int unsigned INT_SIG_EN    = 14;
  localparam int unsigned TIMEOUT_DATA  = 24;

  // RO: responses, buffer, present state (4-9), 16-19 and 21. W1C: interrupt status.
  localparam logic [SD_NUM_REGS-1:0] SD_RO_MASK  = 29'h002F_03F0;
  localparam logic [SD_NUM_REGS-1:0] SD_W1C_MASK = 29'h0000_1000;

  typedef enum logic [1:0] {
    StIdle,
    StAck,
    StWaitRel
  } bus_state_e;

endpackage

// File: rtl/sd_reg_bank_if.sv
// CPU-side req/ack register access bus with byte enables.
interface sd_reg_bank_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                    req;
  logic                    rw;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   data_in;
  logic [DATA_WIDTH/8-1:0] byte_en;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    ack;
  logic                    err;

  modport master (
    output req, rw, addr, data_in, byte_en,
    input  data_out, ack, err
  );

  modport slave (
    input  req, rw, addr, data_in, byte_en,
    output data_out, ack, err
  );
endinterface

// File: rtl/sd_reg_cell.sv
// One register: byte-lane CPU write (RW/RO/W1C), full-width hardware override,
// and sticky set bits ORed in last so a same-cycle set beats any clear.
module sd_reg_cell #(
  parameter int unsigned          DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter bit                   IS_RO       = 1'b0,
  parameter bit                   IS_W1C      = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    cpu_we_i,
  input  logic [DATA_WIDTH-1:0]   cpu_data_i,
  input  logic [DATA_WIDTH/8-1:0] cpu_be_i,
  input  logic                    hw_we_i,
  input  logic [DATA_WIDTH-1:0]   hw_data_i,
  input  logic [DATA_WIDTH-1:0]   set_i,
  output logic [DATA_WIDTH-1:0]   value_o
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] value_d, value_q;

  always_comb begin
    value_d = value_q;
    if (cpu_we_i && !IS_RO) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (cpu_be_i[b]) begin
          if (IS_W1C) begin
            value_d[b*8 +: 8] = value_q[b*8 +: 8] & ~cpu_data_i[b*8 +: 8];
          end else begin
            value_d[b*8 +: 8] = cpu_data_i[b*8 +: 8];
          end
        end
      end
    end
    if (hw_we_i) begin
      value_d = hw_data_i;
    end
    value_d = value_d | set_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      value_q <= RESET_VALUE;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/sd_reg_bank.sv
// SD host controller register bank: CPU req/ack access with per-register access
// types, a hardware update port, interrupt status set inputs and a registered irq.
module sd_reg_bank
  import sd_reg_pkg::*;
#(
  parameter int unsigned                      DATA_WIDTH   = 32,
  parameter int unsigned                      ADDR_WIDTH   = 5,
  parameter int unsigned                      NUM_REGS     = 29,
  parameter logic [NUM_REGS-1:0]              RO_MASK      = '0,
  parameter logic [NUM_REGS-1:0]              W1C_MASK     = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VALUES = '0,
  parameter int unsigned                      INT_STAT_IDX = 12,
  parameter int unsigned                      INT_EN_IDX   = 14
) (
  input  logic                           clk,
  input  logic                           reset,
  sd_reg_bank_if.slave                   bus,
  input  logic                           hw_we,
  input  logic [ADDR_WIDTH-1:0]          hw_addr,
  input  logic [DATA_WIDTH-1:0]          hw_data,
  input  logic [DATA_WIDTH-1:0]          irq_set,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
  output logic                           irq
);

  bus_state_e            state_d, state_q;
  logic                  ack_d, ack_q;
  logic                  err_d, err_q;
  logic                  irq_d, irq_q;
  logic [DATA_WIDTH-1:0] data_out_d, data_out_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  in_range;
  logic                  cpu_access;

  assign in_range   = 32'(bus.addr) < NUM_REGS;
  assign cpu_access = (state_q == StIdle) && bus.req;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    sd_reg_cell #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VALUE (RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH]),
      .IS_RO       (RO_MASK[i]),
      .IS_W1C      (W1C_MASK[i])
    ) u_cell (
      .clk_i      (clk),
      .reset_i    (reset),
      .cpu_we_i   (cpu_access && !bus.rw && (bus.addr == ADDR_WIDTH'(i))),
      .cpu_data_i (bus.data_in),
      .cpu_be_i   (bus.byte_en),
      .hw_we_i    (hw_we && (hw_addr == ADDR_WIDTH'(i))),
      .hw_data_i  (hw_data),
      .set_i      ((i == INT_STAT_IDX) ? irq_set : '0),
      .value_o    (regs[i])
    );
    assign regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

  // Only implemented indices match, so out-of-range reads fall through to zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.addr == ADDR_WIDTH'(i)) begin
        rd_data = regs[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    data_out_d = data_out_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          state_d = StAck;
          ack_d   = 1'b1;
          err_d   = !in_range;
          if (bus.rw) begin
            data_out_d = in_range ? rd_data : '0;
          end
        end
      end
      StAck:     state_d = bus.req ? StWaitRel : StIdle;
      StWaitRel: if (!bus.req) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    irq_d = |(regs[INT_STAT_IDX] & regs[INT_EN_IDX]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      data_out_q <= data_out_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.data_out = data_out_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_sd_reg_bank.sv
// Directed bench for sd_reg_bank with the SD host access map; CPU transactions
// push expected completions to a scoreboard that is drained on each ack.
module tb_sd_reg_bank;
  import sd_reg_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 29;
  localparam logic [NR*DW-1:0] RV = (NR*DW)'(32'h0000_0200) << DW;

  typedef struct {
    logic          is_read;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              hw_we;
  logic [AW-1:0]     hw_addr;
  logic [DW-1:0]     hw_data;
  logic [DW-1:0]     irq_set;
  logic [NR*DW-1:0]  regs_flat;
  logic              irq;

  int   n_asserts = 0;
  int   n_fail    = 0;
  exp_t sb[$];

  sd_reg_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  sd_reg_bank #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .NUM_REGS     (NR),
    .RO_MASK      (SD_RO_MASK),
    .W1C_MASK     (SD_W1C_MASK),
    .RESET_VALUES (RV),
    .INT_STAT_IDX (INT_STAT),
    .INT_EN_IDX   (INT_SIG_EN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .hw_we     (hw_we),
    .hw_addr   (hw_addr),
    .hw_data   (hw_data),
    .irq_set   (irq_set),
    .regs_flat (regs_flat),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] reg_of(int idx);
    return regs_flat[idx*DW +: DW];
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one CPU transaction, optionally with same-cycle irq_set / hw write,
  // holds req for `hold` cycles, and checks the single ack against the scoreboard.
  task automatic cpu_access(input string tag, input logic rd, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [3:0] be, input int hold,
                            input logic [DW-1:0] exp_data, input logic exp_err,
                            input logic [DW-1:0] irq_p, input logic hw_p,
                            input logic [AW-1:0] hw_a, input logic [DW-1:0] hw_d);
    exp_t e;
    exp_t got_e;
    int   acks = 0;
    logic got  = 1'b0;
    e.is_read = rd;
    e.data    = exp_data;
    e.err     = exp_err;
    sb.push_back(e);
    @(negedge clk);
    bus_if.req     = 1'b1;
    bus_if.rw      = rd;
    bus_if.addr    = a;
    bus_if.data_in = d;
    bus_if.byte_en = be;
    irq_set        = irq_p;
    hw_we          = hw_p;
    hw_addr        = hw_a;
    hw_data        = hw_d;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      irq_set = '0;
      hw_we   = 1'b0;
      if (bus_if.ack) begin
        acks++;
        if (!got) begin
          got   = 1'b1;
          got_e = sb.pop_front();
          check({tag, " err"}, DW'(bus_if.err), DW'(got_e.err));
          if (got_e.is_read) check({tag, " data"}, bus_if.data_out, got_e.data);
        end
      end
      if (got && c >= hold) break;
    end
    bus_if.req = 1'b0;
    check({tag, " ack seen"}, DW'(got), DW'(1));
    if (!got) void'(sb.pop_front());
    @(negedge clk);
    if (bus_if.ack) acks++;
    check({tag, " ack count"}, DW'(acks), DW'(1));
  endtask

  initial begin
    reset          = 1'b1;
    bus_if.req     = 1'b0;
    bus_if.rw      = 1'b0;
    bus_if.addr    = '0;
    bus_if.data_in = '0;
    bus_if.byte_en = '0;
    hw_we          = 1'b0;
    hw_addr        = '0;
    hw_data        = '0;
    irq_set        = '0;
    repeat (3) @(negedge clk);
    check("reset reg1", reg_of(BLOCK), 32'h0000_0200);
    check("reset reg2", reg_of(ARGUMENT), 32'h0);
    check("reset ack", DW'(bus_if.ack), 32'h0);
    check("reset irq", DW'(irq), 32'h0);
    check("reset data_out", bus_if.data_out, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Byte-lane write then read back.
    cpu_access("wr reg2", 1'b0, 5'd2, 32'hDEAD_BEEF, 4'b0101, 1, 32'h0, 1'b0, '0, 1'b0, '0, '0);
    check("reg2 lanes", reg_of(ARGUMENT), 32'h00AD_00EF);
    cpu_access("rd reg2", 1'b1, 5'd2, 32'h0, 4'h0, 1, 32'h00AD_00EF, 1'b0, '0, 1'b0, '0, '0);

    // req held for five cycles gives a single access.
    cpu_access("hold wr reg3", 1'b0, 5'd3, 32'h0000_55AA, 4'hF, 5, 32'h0, 1'b0, '0, 1'b0, '0, '0);
    cpu_access("rd reg3", 1'b1, 5'd3, 32'h0, 4'h0, 1, 32'h0000_55AA, 1'b0, '0, 1'b0, '0, '0);
    cpu_access("be0 wr reg3", 1'b0, 5'd3, 32'hFFFF_FFFF, 4'h0, 1, 32'h0, 1'b0, '0, 1'b0, '0, '0);
    check("reg3 be0", reg_of(XFER_CMD), 32'h0000_55AA);

    // Read-only and out-of-range accesses.
    cpu_access("wr ro reg4", 1'b0, 5'd4, 32'hFFFF_FFFF, 4'hF, 1, 32'h0, 1'b0, '0, 1'b0, '0, '0);
    check("reg4 ro", reg_of(RESP0), 32'h0);
    cpu_access("wr addr30", 1'b0, 5'd30, 32'hFFFF_FFFF, 4'hF, 1, 32'h0, 1'b1, '0, 1'b0, '0, '0);
    cpu_access("rd addr30", 1'b1, 5'd30, 32'h0, 4'h0, 1, 32'h0, 1'b1, '0, 1'b0, '0, '0);

    // Interrupt path.
    cpu_access("wr reg14", 1'b0, 5'd14, 32'h1, 4'hF, 1, 32'h0, 1'b0, '0, 1'b0, '0, '0);
    irq_set = 32'h1;
    @(negedge clk);
    irq_set = '0;
    check("irq_set reg12", reg_of(INT_STAT), 32'h1);
    check("irq lag", DW'(irq), 32'h0);
    @(negedge clk);
    check("irq asserted", DW'(irq), 32'h1);
    cpu_access("w1c+set reg12", 1'b0, 5'd12, 32'h1, 4'hF, 1, 32'h0, 1'b0, 32'h1, 1'b0, '0, '0);
    check("reg12 set wins", reg_of(INT_STAT), 32'h1);
    check("irq held", DW'(irq), 32'h1);
    cpu_access("w1c reg12", 1'b0, 5'd12, 32'h1, 4'hF, 1, 32'h0, 1'b0, '0, 1'b0, '0, '0);
    check("reg12 cleared", reg_of(INT_STAT), 32'h0);
    check("irq cleared", DW'(irq), 32'h0);

    // Hardware write beats a same-cycle CPU write.
    cpu_access("hw+cpu reg5", 1'b0, 5'd5, 32'hFFFF_FFFF, 4'hF, 1, 32'h0, 1'b0, '0, 1'b1, 5'd5,
               32'h1234_5678);
    check("reg5 hw wins", reg_of(RESP1), 32'h1234_5678);
    cpu_access("hw+cpu reg3", 1'b0, 5'd3, 32'hFFFF_FFFF, 4'hF, 1, 32'h0, 1'b0, '0, 1'b1, 5'd3,
               32'hCAFE_F00D);
    check("reg3 hw wins", reg_of(XFER_CMD), 32'hCAFE_F00D);

    // Reset in the same cycle as a write request aborts it.
    @(negedge clk);
    bus_if.req     = 1'b1;
    bus_if.rw      = 1'b0;
    bus_if.addr    = 5'd2;
    bus_if.data_in = 32'h1111_1111;
    bus_if.byte_en = 4'hF;
    reset          = 1'b1;
    @(negedge clk);
    bus_if.req = 1'b0;
    reset      = 1'b0;
    check("abort ack", DW'(bus_if.ack), 32'h0);
    check("abort reg2", reg_of(ARGUMENT), 32'h0);
    check("abort reg3", reg_of(XFER_CMD), 32'h0);
    @(negedge clk);
    check("abort ack late", DW'(bus_if.ack), 32'h0);
    check("scoreboard empty", DW'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_reg_bank.md
Name: sd_reg_bank

Overview:
- Parametrised successor to the SD host controller register file.
- Holds NUM_REGS registers of DATA_WIDTH bits, accessed by the CPU over a req/ack handshake with byte enables.
- Adds per-register access types (RW, RO, W1C), a hardware update port for the card-side logic (responses, present state), interrupt status set inputs, and an interrupt output.
- Sits between the CPU bus adapter and the command/data engines, which consume the flattened register bus.

Parameters:
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
- ADDR_WIDTH, 5, CPU and hardware address width.
- NUM_REGS, 29, number of implemented registers; must be ≤ 2**ADDR_WIDTH.
- RO_MASK, 0, NUM_REGS-bit vector; bit i=1 makes reg i read-only to the CPU.
- W1C_MASK, 0, NUM_REGS-bit vector; bit i=1 makes reg i write-1-to-clear for the CPU.
- RESET_VALUES, 0, NUM_REGS*DATA_WIDTH flat vector; reg i resets to slice [i*DATA_WIDTH +: DATA_WIDTH].
- INT_STAT_IDX, 12, index of the interrupt status register.
- INT_EN_IDX, 14, index of the interrupt signal enable register.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  1  CPU transaction request.
- rw  in  1  1 = read, 0 = write.
- addr  in  ADDR_WIDTH  CPU register index.
- data_in  in  DATA_WIDTH  CPU write data.
- byte_en  in  DATA_WIDTH/8  CPU write byte lanes.
- data_out  out  DATA_WIDTH  CPU read data.
- ack  out  1  one-cycle transaction completion pulse.
- err  out  1  asserted with ack when addr ≥ NUM_REGS.
- hw_we  in  1  hardware full-register write strobe.
- hw_addr  in  ADDR_WIDTH  hardware write index.
- hw_data  in  DATA_WIDTH  hardware write data.
- irq_set  in  DATA_WIDTH  bits ORed into reg INT_STAT_IDX.
- regs_flat  out  NUM_REGS*DATA_WIDTH  all registers; reg i at slice [i*DATA_WIDTH +: DATA_WIDTH].
- irq  out  1  interrupt request.

Behaviour:
- Clocking and reset
  - Single clock domain; reset is synchronous and active-high.
  - On reset: every reg takes its RESET_VALUES slice; data_out=0, ack=0, err=0; FSM goes to IDLE.
  - Reset mid-transaction aborts it: no write occurs and no ack is issued.
- Handshake FSM (states IDLE, ACK, WAIT_REL)
  - IDLE: on req=1 at a clock edge, perform the access and go to ACK.
  - ACK: ack=1 for exactly one cycle. Go to WAIT_REL if req=1, else IDLE.
  - WAIT_REL: ack=0. Go to IDLE when req=0.
  - Result: one access per req assertion, and back-to-back accesses need req to drop for at least one cycle.
  - Read latency is one cycle: data_out is valid in the ACK cycle and holds until the next read.
  - A write commits at the same edge that enters ACK.
- Out of range (addr ≥ NUM_REGS)
  - Reads return 0; writes are dropped.
  - err=1 during the ACK cycle, 0 otherwise.
- CPU write rules, per byte lane with byte_en[b]=1
  - RW reg: lane ← data_in lane.
  - RO reg: no change; ack is issued and err stays 0.
  - W1C reg: reg &= ~(data_in & lane mask).
  - byte_en=0 gives a write that is acknowledged but changes nothing.
- Hardware port
  - hw_we writes hw_data to hw_addr unconditionally, ignoring RO/W1C masks and byte enables.
  - Out-of-range hw_addr is ignored.
  - hw_we and a CPU write to the same reg in the same cycle: hw_we wins.
- Interrupt status (reg INT_STAT_IDX)
  - Next value = ((current, after any CPU W1C clear) | irq_set); a bit set and cleared in the same cycle ends up set.
  - If hw_we also targets INT_STAT_IDX, next value = hw_data | irq_set.
- irq is registered: irq = |(reg[INT_STAT_IDX] & reg[INT_EN_IDX]), with one cycle lag after the status update.
- regs_flat is driven directly from register storage, with no extra latency.

Decomposition:
- Shared package sd_reg_pkg:
  - register index constants (SDMA_ADDR=0, BLOCK=1, ARGUMENT=2, XFER_CMD=3, RESP0..3=4..7, BUF_DATA=8, PRESENT_STATE=9, …, INT_STAT=12, INT_STAT_EN=13, INT_SIG_EN=14, TIMEOUT_DATA=24);
  - default RO_MASK / W1C_MASK constants for the SD host map (RO: 4–9, 16–19, 21; W1C: 12);
  - FSM state typedef.
- One natural sub-module: sd_reg_cell, a single register with byte-lane RW/RO/W1C write logic plus hardware override, instantiated NUM_REGS times by a generate loop.

Test Plan:
1. Reset with RESET_VALUES reg1=0x0000_0200 -> regs_flat reg1=0x200; ack=0; irq=0; data_out=0.
2. Write reg2=0xDEADBEEF with byte_en=4'b0101 over a zeroed reg, then read reg2 -> reg2=0x00AD00EF; ack high for exactly one cycle per req; read data_out=0x00AD00EF in the ACK cycle.
3. req held high for 5 cycles on a write -> exactly one ack, FSM stays in WAIT_REL until req=0; the next req is serviced normally.
4. CPU write 0xFFFF_FFFF to RO reg4 -> reg4 unchanged, ack=1, err=0. Access addr=30 -> err=1, read returns 0.
5. Interrupt path:
   - irq_set=0x1 with reg14=0x1 -> reg12=0x1, irq=1 one cycle later.
   - CPU writes 0x1 to reg12 in the same cycle as irq_set=0x1 -> bit stays set.
   - CPU writes 0x1 with irq_set=0 -> bit clears, irq=0.
6. hw_we to reg5=0x1234_5678 in the same cycle as a CPU write of 0xFFFF_FFFF to reg5 -> reg5=0x1234_5678.
